// File: rtl/lane_map_pkg.sv
// Shared types and the per-lane operation for the lane map engine.
package lane_map_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_NEG  = 2'd1,
    OP_ABS  = 2'd2,
    OP_INCS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Packages cannot take parameters, so the width-generic lane function lives in a class wrapper.
  virtual class lane_fn_c #(parameter int unsigned W = 32);
    static function logic [W-1:0] lane_fn(input op_e op, input logic signed [W-1:0] x,
                                           output logic sat);
      logic signed [W-1:0] smin;
      logic signed [W-1:0] smax;
      logic signed [W-1:0] res;
      smin = {1'b1, {(W-1){1'b0}}};
      smax = ~smin;
      sat  = 1'b0;
      res  = x;
      case (op)
        OP_PASS: res = x;
        OP_NEG: begin
          if (x == smin) begin
            res = smax;
            sat = 1'b1;
          end else begin
            res = -x;
          end
        end
        OP_ABS: begin
          if (x == smin) begin
            res = smax;
            sat = 1'b1;
          end else if (x < 0) begin
            res = -x;
          end else begin
            res = x;
          end
        end
        OP_INCS: begin
          if (x == smax) begin
            res = smax;
            sat = 1'b1;
          end else begin
            res = x + {{(W-1){1'b0}}, 1'b1};
          end
        end
        default: res = x;
      endcase
      return res;
    endfunction
  endclass

endpackage

// File: rtl/lane_map_unit.sv
// One combinational lane: applies the selected operation and flags saturation.
module lane_map_unit
  import lane_map_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o,
  output logic             sat_o
);

  // Evaluate the lane function for this element.
  always_comb begin
    sat_o = 1'b0;
    y_o   = lane_fn_c#(WIDTH)::lane_fn(op_i, x_i, sat_o);
  end

endmodule

// File: rtl/lane_map_seq.sv
// Sequential per-lane map engine: walks a captured vector UNROLL lanes per cycle.
module lane_map_seq
  import lane_map_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LANES  = 10,
  parameter int unsigned UNROLL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  op_e                    in_op,
  input  logic [LANES*WIDTH-1:0] in_x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_y,
  output logic                   out_sat
);

  localparam int unsigned IdxW = $clog2(LANES + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - UNROLL);
  localparam logic [IdxW-1:0] Step    = IdxW'(UNROLL);

  if (WIDTH < 2) begin : g_bad_width
    $error("lane_map_seq: WIDTH must be at least 2");
  end
  if (UNROLL == 0 || (LANES % UNROLL) != 0) begin : g_bad_unroll
    $error("lane_map_seq: UNROLL must divide LANES");
  end

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  op_e                    op_q, op_d;
  logic [LANES*WIDTH-1:0] x_q, x_d;
  logic [LANES*WIDTH-1:0] y_q, y_d;
  logic                   sat_q, sat_d;
  logic                   accept;

  logic [WIDTH-1:0]       ux [UNROLL];
  logic [WIDTH-1:0]       uy [UNROLL];
  logic [UNROLL-1:0]      usat;

  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE can hand straight back to RUN on a same-cycle accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LastIdx) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; in_ready is combinational from out_ready in DONE.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    out_y     = y_q;
    out_sat   = sat_q;
  end

  // Route lanes idx .. idx+UNROLL-1 of the captured vector to the units.
  always_comb begin
    for (int g = 0; g < int'(UNROLL); g++) begin
      ux[g] = '0;
      for (int l = 0; l < int'(LANES); l++) begin
        if (int'(idx_q) + g == l) ux[g] = x_q[l*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar g = 0; g < int'(UNROLL); g++) begin : g_unit
    lane_map_unit #(
      .WIDTH(WIDTH)
    ) u_unit (
      .op_i (op_q),
      .x_i  (ux[g]),
      .y_o  (uy[g]),
      .sat_o(usat[g])
    );
  end

  // Datapath next state: capture on accept, write one lane group per RUN cycle.
  always_comb begin
    idx_d = idx_q;
    op_d  = op_q;
    x_d   = x_q;
    y_d   = y_q;
    sat_d = sat_q;
    if (accept) begin
      x_d   = in_x;
      op_d  = in_op;
      idx_d = '0;
      sat_d = 1'b0;
    end
    if (state_q == RUN) begin
      for (int l = 0; l < int'(LANES); l++) begin
        for (int g = 0; g < int'(UNROLL); g++) begin
          if (int'(idx_q) + g == l) y_d[l*WIDTH +: WIDTH] = uy[g];
        end
      end
      sat_d = sat_q | (|usat);
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + Step;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      op_q  <= OP_PASS;
      x_q   <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      op_q  <= op_d;
      x_q   <= x_d;
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_lane_map_seq.sv
// Directed bench for lane_map_seq: three 32-bit instances (UNROLL 1/5/10) and one 8-bit instance.
module tb_lane_map_seq;
  import lane_map_pkg::*;

  typedef logic signed [31:0] v32_t [10];
  typedef logic signed [7:0]  v8_t  [10];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, out_ready;
  op_e          in_op;
  logic [319:0] in_x;
  logic         rdy_a, vld_a, sat_a, rdy_b, vld_b, sat_b, rdy_c, vld_c, sat_c;
  logic [319:0] y_a, y_b, y_c;

  logic         in_valid8, out_ready8;
  op_e          in_op8;
  logic [79:0]  in_x8;
  logic         rdy8, vld8, sat8;
  logic [79:0]  y8;

  int errors = 0;
  int checks = 0;

  lane_map_seq #(.WIDTH(32), .LANES(10), .UNROLL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_op(in_op),
    .in_x(in_x), .out_valid(vld_a), .out_ready(out_ready), .out_y(y_a), .out_sat(sat_a));

  lane_map_seq #(.WIDTH(32), .LANES(10), .UNROLL(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_op(in_op),
    .in_x(in_x), .out_valid(vld_b), .out_ready(out_ready), .out_y(y_b), .out_sat(sat_b));

  lane_map_seq #(.WIDTH(32), .LANES(10), .UNROLL(10)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .in_op(in_op),
    .in_x(in_x), .out_valid(vld_c), .out_ready(out_ready), .out_y(y_c), .out_sat(sat_c));

  lane_map_seq #(.WIDTH(8), .LANES(10), .UNROLL(1)) dut_8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(rdy8), .in_op(in_op8),
    .in_x(in_x8), .out_valid(vld8), .out_ready(out_ready8), .out_y(y8), .out_sat(sat8));

  function automatic logic [319:0] pack32(input v32_t a);
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = a[i];
    return r;
  endfunction

  function automatic logic [79:0] pack8(input v8_t a);
    logic [79:0] r;
    for (int i = 0; i < 10; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency counts clock edges starting with the edge that takes the handshake.
  task automatic measure(output int la, output int lb, output int lc);
    la = 0; lb = 0; lc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
      end
      if (vld_a && la == 0) la = c;
      if (vld_b && lb == 0) lb = c;
      if (vld_c && lc == 0) lc = c;
      if (la != 0 && lb != 0 && lc != 0) break;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_a", 320'(vld_a), 320'(0));
  endtask

  task automatic run32(input string tag, input op_e op, input v32_t x, input v32_t ey,
                       input logic es);
    int la, lb, lc;
    in_op = op; in_x = pack32(x); in_valid = 1'b1; out_ready = 1'b0;
    measure(la, lb, lc);
    chk({tag, "/lat_u1"}, 320'(la), 320'(11));
    chk({tag, "/lat_u5"}, 320'(lb), 320'(3));
    chk({tag, "/lat_u10"}, 320'(lc), 320'(2));
    chk({tag, "/y_u1"}, y_a, pack32(ey));
    chk({tag, "/y_u5"}, y_b, pack32(ey));
    chk({tag, "/y_u10"}, y_c, pack32(ey));
    chk({tag, "/sat_u1"}, 320'(sat_a), 320'(es));
    chk({tag, "/sat_u5"}, 320'(sat_b), 320'(es));
    chk({tag, "/sat_u10"}, 320'(sat_c), 320'(es));
    release_out();
  endtask

  task automatic run8(input string tag, input op_e op, input v8_t x, input v8_t ey,
                      input logic es);
    int l;
    l = 0;
    in_op8 = op; in_x8 = pack8(x); in_valid8 = 1'b1; out_ready8 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) in_valid8 = 1'b0;
      if (vld8) begin
        l = c;
        break;
      end
    end
    chk({tag, "/lat"}, 320'(l), 320'(11));
    chk({tag, "/y"}, 320'(y8), 320'(pack8(ey)));
    chk({tag, "/sat"}, 320'(sat8), 320'(es));
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    v32_t xa, ya, xb;
    v8_t  x8, e8;
    logic [319:0] ystore;
    logic stable, seen;
    int la, lb, lc;

    rst_n = 1'b0; in_valid = 1'b0; in_op = OP_PASS; in_x = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_op8 = OP_PASS; in_x8 = '0; out_ready8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 320'(rdy_a), 320'(1));
    chk("rst_out_valid", 320'(vld_a), 320'(0));
    chk("rst_out_y", y_a, 320'(0));
    chk("rst_out_sat", 320'(sat_a), 320'(0));
    chk("rst_in_ready8", 320'(rdy8), 320'(1));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) xa[i] = i;
    run32("pass_ramp", OP_PASS, xa, xa, 1'b0);

    xa = '{5, -7, 0, 1, -1, 100, -100, 32'sh7fffffff, 32'sh80000000, 3};
    ya = '{-5, 7, 0, -1, 1, -100, 100, 32'sh80000001, 32'sh7fffffff, -3};
    run32("neg_mix", OP_NEG, xa, ya, 1'b1);

    xa = '{0, -1, 7, 32'sh7fffffff, 32'sh80000000, 10, 20, 30, 40, 50};
    ya = '{1, 0, 8, 32'sh7fffffff, 32'sh80000001, 11, 21, 31, 41, 51};
    run32("incs_mix", OP_INCS, xa, ya, 1'b1);

    xa = '{-3, 3, 0, -1000, 999, -1, 1, -2, 2, 32'sh80000001};
    ya = '{3, 3, 0, 1000, 999, 1, 1, 2, 2, 32'sh7fffffff};
    run32("abs_nosat", OP_ABS, xa, ya, 1'b0);

    x8 = '{8'sh80, -8'sd5, 8'sd7, 8'sd0, 8'sd1, -8'sd1, 8'sd127, -8'sd127, 8'sd2, -8'sd2};
    e8 = '{8'sd127, 8'sd5, 8'sd7, 8'sd0, 8'sd1, 8'sd1, 8'sd127, 8'sd127, 8'sd2, 8'sd2};
    run8("w8_abs", OP_ABS, x8, e8, 1'b1);

    x8 = '{8'sd127, 8'sd0, -8'sd1, 8'sh80, 8'sd5, 8'sd10, -8'sd10, 8'sd126, 8'sd50, -8'sd50};
    e8 = '{8'sd127, 8'sd1, 8'sd0, -8'sd127, 8'sd6, 8'sd11, -8'sd9, 8'sd127, 8'sd51, -8'sd49};
    run8("w8_incs", OP_INCS, x8, e8, 1'b1);

    x8 = '{8'sd5, -8'sd5, 8'sd0, 8'sd127, -8'sd127, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd6};
    e8 = '{-8'sd5, 8'sd5, 8'sd0, -8'sd127, 8'sd127, -8'sd1, -8'sd2, -8'sd3, -8'sd4, -8'sd6};
    run8("w8_neg", OP_NEG, x8, e8, 1'b0);

    x8 = '{8'sh80, 8'sd127, -8'sd1, 8'sd0, 8'sd9, 8'sd8, 8'sd7, 8'sd6, 8'sd5, 8'sd4};
    run8("w8_pass_min", OP_PASS, x8, x8, 1'b0);

    // Backpressure: hold the result, then re-accept in the same cycle out_ready rises.
    for (int i = 0; i < 10; i++) xa[i] = i * 3 + 1000;
    in_op = OP_PASS; in_x = pack32(xa); in_valid = 1'b1; out_ready = 1'b0;
    measure(la, lb, lc);
    chk("bp_lat", 320'(la), 320'(11));
    chk("bp_y", y_a, pack32(xa));
    ystore = y_a;
    stable = 1'b1;
    in_x = '1;
    in_op = OP_NEG;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (y_a !== ystore || vld_a !== 1'b1 || rdy_a !== 1'b0) stable = 1'b0;
    end
    chk("bp_hold", 320'(stable), 320'(1));
    chk("bp_in_ready_low", 320'(rdy_a), 320'(0));
    chk("bp_y_after_hold", y_a, pack32(xa));
    for (int i = 0; i < 10; i++) begin
      xb[i] = -i;
      ya[i] = i;
    end
    in_op = OP_NEG; in_x = pack32(xb); in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 320'(rdy_a), 320'(1));
    measure(la, lb, lc);
    chk("b2b_lat_u1", 320'(la), 320'(11));
    chk("b2b_lat_u5", 320'(lb), 320'(3));
    chk("b2b_lat_u10", 320'(lc), 320'(2));
    chk("b2b_y_u1", y_a, pack32(ya));
    chk("b2b_y_u5", y_b, pack32(ya));
    chk("b2b_sat", 320'(sat_a), 320'(0));
    release_out();

    // Reset during RUN discards the partial vector.
    for (int i = 0; i < 10; i++) xa[i] = i + 50;
    in_op = OP_PASS; in_x = pack32(xa); in_valid = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (vld_a) seen = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 320'(vld_a), 320'(0));
    chk("mid_rst_y", y_a, 320'(0));
    chk("mid_rst_in_ready", 320'(rdy_a), 320'(1));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (vld_a) seen = 1'b1;
    end
    chk("mid_rst_no_valid", 320'(seen), 320'(0));
    out_ready = 1'b0;

    for (int i = 0; i < 10; i++) xa[i] = i * 7 - 20;
    run32("post_rst_pass", OP_PASS, xa, xa, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
